// File: rtl/score_pkg.sv
// Shared types and helpers for the BCD score datapath.
//   bcd_t      : one BCD digit
//   bcd_wide_t : widest score the helpers accept (MAX_DIGITS digits)
//   state_t    : digit-serial adder sequencer states
//   bcd_gt     : unsigned BCD magnitude compare, MSD first
//   bcd_sat9   : clamps a non-BCD digit (10..15) to 9
package score_pkg;

  typedef logic [3:0] bcd_t;

  localparam int MAX_DIGITS = 16;
  typedef logic [MAX_DIGITS-1:0][3:0] bcd_wide_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_COMMIT
  } state_t;

  // Callers zero-extend narrower scores into bcd_wide_t; leading zero digits
  // compare equal and so do not affect the result.
  function automatic logic bcd_gt(input bcd_wide_t a, input bcd_wide_t b);
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return (a[i] > b[i]);
    end
    return 1'b0;
  endfunction

  function automatic bcd_t bcd_sat9(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: sum/cout = a + b + cin, decimal-corrected.
// Ports:
//   a, b  : BCD digits (0..9)
//   cin   : carry in
//   sum   : BCD result digit
//   cout  : decimal carry out
module bcd_digit_add
  import score_pkg::*;
(
  input  bcd_t a,
  input  bcd_t b,
  input  logic cin,
  output bcd_t sum,
  output logic cout
);

  logic [4:0] raw;

  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    raw  = 5'(a) + 5'(b) + 5'(cin);
    cout = (raw > 5'd9);
    sum  = cout ? 4'(raw - 5'd10) : raw[3:0];
  end

endmodule

// File: rtl/score_bank.sv
// Multi-player BCD score accumulator. Add requests are queued, then added
// one digit per cycle (LSD first) into the target player's score, clamped at
// all-nines. Tracks the highest score ever committed.
// Ports:
//   clk, resetN            : clock, async active-low reset
//   add_valid/player/value : add request; accepted when add_ready
//   add_ready              : queue not full
//   clear, clear_player    : zero one player's score and its saturated flag
//   score                  : per-player scores, updated only at commit or clear
//   hi_score, hi_new       : all-time high score, 1-cycle pulse on increase
//   saturated              : sticky per-player clamp flag
//   dropped                : 1-cycle pulse for a request refused by a full queue
//   busy                   : queue non-empty or adder active
module score_bank
  import score_pkg::*;
#(
  parameter  int DIGITS  = 4,
  parameter  int PLAYERS = 2,
  parameter  int QDEPTH  = 4,
  localparam int PW      = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                add_valid,
  input  logic [PW-1:0]                       add_player,
  input  logic [DIGITS-1:0][3:0]              add_value,
  output logic                                add_ready,
  input  logic                                clear,
  input  logic [PW-1:0]                       clear_player,
  output logic [PLAYERS-1:0][DIGITS-1:0][3:0] score,
  output logic [DIGITS-1:0][3:0]              hi_score,
  output logic                                hi_new,
  output logic [PLAYERS-1:0]                  saturated,
  output logic                                dropped,
  output logic                                busy
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef struct packed {
    logic [PW-1:0]          player;
    logic [DIGITS-1:0][3:0] value;
  } req_t;

  // ---------------- request queue ----------------
  req_t        q_mem [QDEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        q_empty, q_full, push, pop;

  state_t                 state;
  req_t                   cur;
  logic [DIGITS-1:0][3:0] a_reg, b_reg, res, commit_val;
  logic                   carry, cancel, clear_same, hi_up;
  logic [CW-1:0]          cnt;
  bcd_t                   dsum;
  logic                   dcout;
  bcd_wide_t              res_w, hi_w;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
  assign q_empty   = (wr_ptr == rd_ptr);
  assign q_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Readiness comes from registered pointers, so a pop in the same cycle
  // never frees a slot for a push to a full queue.
  assign add_ready = ~q_full;
  assign push      = add_valid & ~q_full;
  assign pop       = (state == S_IDLE) & ~q_empty;
  assign busy      = ~q_empty | (state != S_IDLE);

  // NOTE: storage array has no reset; emptiness is defined by the pointers
  // alone, so resetting the data would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr[AW-1:0]] <= {add_player, add_value};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      dropped <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      dropped <= add_valid & q_full;
    end
  end

  // ---------------- digit-serial adder ----------------
  bcd_digit_add u_digit (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout)
  );

  // A clear aimed at the in-flight player invalidates its latched operand.
  assign clear_same = clear && (clear_player == cur.player) && (state != S_IDLE);

  always_comb begin
    commit_val = carry ? {DIGITS{4'd9}} : res;
    res_w = '0;
    hi_w  = '0;
    res_w[DIGITS-1:0] = commit_val;
    hi_w[DIGITS-1:0]  = hi_score;
    hi_up = bcd_gt(res_w, hi_w);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= S_IDLE;
      cur       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      cancel    <= 1'b0;
      score     <= '0;
      saturated <= '0;
      hi_score  <= '0;
      hi_new    <= 1'b0;
    end else begin
      hi_new <= 1'b0;

      if (clear) begin
        score[clear_player]     <= '0;
        saturated[clear_player] <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (!q_empty) begin
            cur   <= q_mem[rd_ptr[AW-1:0]];
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          a_reg <= score[cur.player];
          for (int i = 0; i < DIGITS; i++) b_reg[i] <= bcd_sat9(cur.value[i]);
          carry  <= 1'b0;
          cnt    <= '0;
          cancel <= clear_same;
          state  <= S_ADD;
        end

        // Operands shift down one digit per cycle; result digits enter at the
        // top so after DIGITS cycles res holds the sum in natural order.
        S_ADD: begin
          for (int i = 0; i < DIGITS - 1; i++) begin
            a_reg[i] <= a_reg[i+1];
            b_reg[i] <= b_reg[i+1];
            res[i]   <= res[i+1];
          end
          a_reg[DIGITS-1] <= '0;
          b_reg[DIGITS-1] <= '0;
          res[DIGITS-1]   <= dsum;
          carry           <= dcout;
          if (clear_same) cancel <= 1'b1;
          if (cnt == CW'(DIGITS - 1)) state <= S_COMMIT;
          else                        cnt   <= cnt + 1'b1;
        end

        S_COMMIT: begin
          if (!cancel && !clear_same) begin
            score[cur.player] <= commit_val;
            if (carry) saturated[cur.player] <= 1'b1;
            if (hi_up) begin
              hi_score <= commit_val;
              hi_new   <= 1'b1;
            end
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_bank.sv
// Self-checking bench for score_bank (DIGITS=4, PLAYERS=2, QDEPTH=4):
// a table of single adds with hand-computed results, plus directed
// sequences for latency, queue overflow, clear-vs-add and async reset.
module tb_score_bank;

  localparam int DIGITS  = 4;
  localparam int PLAYERS = 2;
  localparam int QDEPTH  = 4;

  logic                                clk = 1'b0;
  logic                                resetN = 1'b0;
  logic                                add_valid = 1'b0;
  logic [0:0]                          add_player = '0;
  logic [DIGITS-1:0][3:0]              add_value = '0;
  logic                                add_ready;
  logic                                clear = 1'b0;
  logic [0:0]                          clear_player = '0;
  logic [PLAYERS-1:0][DIGITS-1:0][3:0] score;
  logic [DIGITS-1:0][3:0]              hi_score;
  logic                                hi_new;
  logic [PLAYERS-1:0]                  saturated;
  logic                                dropped;
  logic                                busy;

  score_bank #(.DIGITS(DIGITS), .PLAYERS(PLAYERS), .QDEPTH(QDEPTH)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .add_valid    (add_valid),
    .add_player   (add_player),
    .add_value    (add_value),
    .add_ready    (add_ready),
    .clear        (clear),
    .clear_player (clear_player),
    .score        (score),
    .hi_score     (hi_score),
    .hi_new       (hi_new),
    .saturated    (saturated),
    .dropped      (dropped),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int drop_cnt  = 0;
  int hinew_cnt = 0;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (dropped) drop_cnt++;
    if (hi_new)  hinew_cnt++;
  end

  typedef struct {
    logic [0:0]  player;
    logic [15:0] value;
    logic [15:0] exp_score;
    logic [15:0] exp_hi;
    logic        exp_sat;
    int          exp_hinew;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    add_valid = 1'b0;
    clear = 1'b0;
    step();
    step();
    resetN = 1'b1;
  endtask

  initial begin
    int h0, d0;

    vecs[0] = '{1'b0, 16'h0025, 16'h0025, 16'h0025, 1'b0, 1};
    vecs[1] = '{1'b1, 16'h0010, 16'h0010, 16'h0025, 1'b0, 0};
    vecs[2] = '{1'b0, 16'h0974, 16'h0999, 16'h0999, 1'b0, 1};
    vecs[3] = '{1'b0, 16'h0001, 16'h1000, 16'h1000, 1'b0, 1};
    vecs[4] = '{1'b1, 16'h0990, 16'h1000, 16'h1000, 1'b0, 0};
    vecs[5] = '{1'b1, 16'h0001, 16'h1001, 16'h1001, 1'b0, 1};
    vecs[6] = '{1'b1, 16'h8989, 16'h9990, 16'h9990, 1'b0, 1};
    vecs[7] = '{1'b1, 16'h0015, 16'h9999, 16'h9999, 1'b1, 1};
    vecs[8] = '{1'b0, 16'h00F0, 16'h1090, 16'h9999, 1'b0, 0};
    vecs[9] = '{1'b0, 16'h0A0B, 16'h1999, 16'h9999, 1'b0, 0};

    // ---- reset state ----
    do_reset();
    check("rst_score", 32'(score), 32'h0);
    check("rst_hi", 32'(hi_score), 32'h0);
    check("rst_ready", 32'(add_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sat", 32'(saturated), 32'd0);

    // ---- latency: update exactly 6 edges after the pop edge ----
    add_valid = 1'b1; add_player = 1'b0; add_value = 16'h0025;
    step();                                   // push edge
    add_valid = 1'b0;
    step();                                   // pop edge
    for (int i = 0; i < 5; i++) step();
    check("lat_before", 32'(score[0]), 32'h0);
    step();
    check("lat_at", 32'(score[0]), 32'h0025);
    check("lat_hi", 32'(hi_score), 32'h0025);
    check("lat_hinew", 32'(hi_new), 32'd1);
    step();
    check("lat_hinew_off", 32'(hi_new), 32'd0);

    // ---- table of single adds ----
    do_reset();
    for (int v = 0; v < 10; v++) begin
      h0 = hinew_cnt;
      add_valid = 1'b1; add_player = vecs[v].player; add_value = vecs[v].value;
      step();
      add_valid = 1'b0;
      wait_idle($sformatf("vec%0d", v));
      step();
      check($sformatf("vec%0d_score", v), 32'(score[vecs[v].player]), 32'(vecs[v].exp_score));
      check($sformatf("vec%0d_hi", v), 32'(hi_score), 32'(vecs[v].exp_hi));
      check($sformatf("vec%0d_sat", v), 32'(saturated[vecs[v].player]), 32'(vecs[v].exp_sat));
      check($sformatf("vec%0d_hinew", v), 32'(hinew_cnt - h0), 32'(vecs[v].exp_hinew));
    end

    // ---- clear saturated player 1 ----
    clear = 1'b1; clear_player = 1'b1;
    step();
    clear = 1'b0;
    check("clr_score1", 32'(score[1]), 32'h0);
    check("clr_sat1", 32'(saturated[1]), 32'd0);
    check("clr_hi_kept", 32'(hi_score), 32'h9999);
    check("clr_score0_kept", 32'(score[0]), 32'h1999);

    // ---- async reset mid-ADD ----
    add_valid = 1'b1; add_player = 1'b0; add_value = 16'h0001;
    step();
    add_valid = 1'b0;
    step();
    step();
    resetN = 1'b0;
    #1;
    check("arst_score", 32'(score), 32'h0);
    check("arst_hi", 32'(hi_score), 32'h0);
    check("arst_ready", 32'(add_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    step();
    resetN = 1'b1;

    // ---- overflow: 5 back-to-back adds while busy ----
    d0 = drop_cnt;
    add_valid = 1'b1; add_player = 1'b1; add_value = 16'h0001;
    step();
    for (int k = 0; k < 5; k++) begin
      add_player = 1'b0; add_value = 16'h0001;
      check($sformatf("ovf_ready%0d", k), 32'(add_ready), (k < 4) ? 32'd1 : 32'd0);
      step();
    end
    add_valid = 1'b0;
    check("ovf_dropped", 32'(dropped), 32'd1);
    wait_idle("ovf");
    step();
    check("ovf_drop_cnt", 32'(drop_cnt - d0), 32'd1);
    check("ovf_score0", 32'(score[0]), 32'h0004);
    check("ovf_score1", 32'(score[1]), 32'h0001);

    // ---- clear during ADD of the same player ----
    do_reset();
    add_valid = 1'b1; add_player = 1'b0; add_value = 16'h0100;
    step();
    add_valid = 1'b0;
    wait_idle("cadd_setup");
    add_valid = 1'b1; add_value = 16'h0020;
    step();                                   // push A
    add_value = 16'h0003;
    step();                                   // push B, pop A
    add_valid = 1'b0;
    step();                                   // LOAD -> ADD
    step();                                   // first digit
    clear = 1'b1; clear_player = 1'b0;
    step();
    clear = 1'b0;
    check("cadd_cleared", 32'(score[0]), 32'h0);
    step(); step(); step();                   // past A's commit
    check("cadd_cancelled", 32'(score[0]), 32'h0);
    wait_idle("cadd");
    check("cadd_next", 32'(score[0]), 32'h0003);
    check("cadd_hi", 32'(hi_score), 32'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
